// File: rtl/pipe_reg_pkg.sv
// rtl/pipe_reg_pkg.sv - shared constants and sizing helpers for the elastic register bank
package pipe_reg_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 3;
  localparam int CHAIN_LEN = DEF_DEPTH * (DEF_WIDTH + 1);

  // Width of a counter holding 0..n-1; never narrower than one bit
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Scan chain length: one valid flop plus the data flops per stage
  function automatic int chain_len(input int width, input int depth);
    return depth * (width + 1);
  endfunction

endpackage

// File: rtl/pipe_reg_stage.sv
// rtl/pipe_reg_stage.sv - one pipeline stage: valid flop, data flops, load enable and scan mux
module pipe_reg_stage
  import pipe_reg_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             se,
  input  logic             si,
  output logic             so,
  input  logic             load,
  input  logic             v_in,
  input  logic [WIDTH-1:0] d_in,
  output logic             v,
  output logic [WIDTH-1:0] d
);

  // Reset wins, then scan shift (si -> v -> d[0] .. d[WIDTH-1]), then handshake load.
  // Data only moves with a valid item so an emptied stage keeps its last value.
  always_ff @(posedge clk) begin
    if (!rstb) begin
      v <= 1'b0;
      d <= RESET_VAL;
    end else if (se) begin
      {d, v} <= ({d, v} << 1) | {{WIDTH{1'b0}}, si};
    end else if (load) begin
      v <= v_in;
      if (v_in) begin
        d <= d_in;
      end
    end
  end

  assign so = d[WIDTH-1];

endmodule

// File: rtl/pipe_reg_bank.sv
// rtl/pipe_reg_bank.sv - WIDTH x DEPTH elastic register pipeline with scan chain and occupancy count
module pipe_reg_bank
  import pipe_reg_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter int               DEPTH     = 3,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                              CLK,
  input  logic                              RSTB,
  input  logic                              SE,
  input  logic                              SI,
  output logic                              SO,
  input  logic                              IN_VALID,
  output logic                              IN_READY,
  input  logic [WIDTH-1:0]                  D,
  output logic                              OUT_VALID,
  input  logic                              OUT_READY,
  output logic [WIDTH-1:0]                  Q,
  output logic [WIDTH-1:0]                  QN,
  output logic [clog2_min1(DEPTH+1)-1:0]    COUNT
);

  localparam int CW = clog2_min1(DEPTH + 1);

  logic [DEPTH-1:0] v;
  logic [DEPTH-1:0] rdy;
  logic [WIDTH-1:0] d [DEPTH];
  logic [DEPTH:0]   scan;

  assign scan[0] = SI;

  genvar i;
  generate
    for (i = 0; i < DEPTH; i++) begin : g_stage
      logic             v_prev;
      logic [WIDTH-1:0] d_prev;

      if (i == 0) begin : g_head
        assign v_prev = IN_VALID;
        assign d_prev = D;
      end else begin : g_body
        assign v_prev = v[i-1];
        assign d_prev = d[i-1];
      end

      // A stage can take new data if the sink drains or any stage from here to the
      // output is a bubble; flattened so the chain has no combinational self-reference.
      assign rdy[i] = OUT_READY | ~(&v[DEPTH-1:i]);

      pipe_reg_stage #(
        .WIDTH     (WIDTH),
        .RESET_VAL (RESET_VAL)
      ) u_stage (
        .clk  (CLK),
        .rstb (RSTB),
        .se   (SE),
        .si   (scan[i]),
        .so   (scan[i+1]),
        .load (rdy[i]),
        .v_in (v_prev),
        .d_in (d_prev),
        .v    (v[i]),
        .d    (d[i])
      );
    end
  endgenerate

  // Occupancy is the population count of the stage valid flops
  always_comb begin
    COUNT = '0;
    for (int k = 0; k < DEPTH; k++) begin
      COUNT = COUNT + CW'(v[k]);
    end
  end

  assign IN_READY  = rdy[0] & ~SE;
  assign OUT_VALID = v[DEPTH-1] & ~SE;
  assign Q         = d[DEPTH-1];
  assign QN        = ~d[DEPTH-1];
  assign SO        = scan[DEPTH];

endmodule

// File: tb/tb_pipe_reg_bank.sv
// tb/tb_pipe_reg_bank.sv - directed scoreboard bench for pipe_reg_bank
module tb_pipe_reg_bank;
  import pipe_reg_pkg::*;

  localparam int         WIDTH = 8;
  localparam int         DEPTH = 3;
  localparam logic [7:0] RV    = 8'hA5;
  localparam int         CL    = chain_len(WIDTH, DEPTH);

  logic             CLK = 1'b0;
  logic             RSTB, SE, SI, SO;
  logic             IN_VALID, IN_READY, OUT_VALID, OUT_READY;
  logic [WIDTH-1:0] D, Q, QN;
  logic [1:0]       COUNT;

  int errors = 0;
  int checks = 0;
  logic [WIDTH-1:0] sb[$];

  always #5 CLK = ~CLK;

  pipe_reg_bank #(
    .WIDTH     (WIDTH),
    .DEPTH     (DEPTH),
    .RESET_VAL (RV)
  ) dut (
    .CLK       (CLK),
    .RSTB      (RSTB),
    .SE        (SE),
    .SI        (SI),
    .SO        (SO),
    .IN_VALID  (IN_VALID),
    .IN_READY  (IN_READY),
    .D         (D),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY),
    .Q         (Q),
    .QN        (QN),
    .COUNT     (COUNT)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, record transfers mid-cycle, return 1 time unit after the edge
  task automatic cyc(input logic iv, input logic [WIDTH-1:0] dd, input logic ordy);
    logic [WIDTH-1:0] exp;
    IN_VALID  = iv;
    D         = dd;
    OUT_READY = ordy;
    #3;
    if (RSTB) begin
      if (IN_VALID && IN_READY) sb.push_back(D);
      if (OUT_VALID && OUT_READY) begin
        if (sb.size() == 0) begin
          check("sb_underflow", 32'd1, 32'd0);
        end else begin
          exp = sb.pop_front();
          check("q_order", Q, exp);
        end
      end
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (sb.size() > 0 && n < budget) begin
      cyc(1'b0, '0, 1'b1);
      n++;
    end
    check("drain_done", sb.size(), 0);
  endtask

  task automatic do_reset();
    RSTB = 1'b0;
    repeat (2) begin
      @(posedge CLK);
      #1;
    end
  endtask

  initial begin
    logic [CL-1:0] pat, prior;

    RSTB = 1'b0; SE = 1'b0; SI = 1'b0;
    IN_VALID = 1'b0; OUT_READY = 1'b0; D = '0;

    // Reset state
    do_reset();
    check("rst_q", Q, RV);
    check("rst_qn", QN, 8'h5A);
    check("rst_ovalid", OUT_VALID, 0);
    check("rst_count", COUNT, 0);
    check("rst_so", SO, 1);
    check("rst_iready", IN_READY, 1);
    RSTB = 1'b1;
    #1;
    check("rel_iready", IN_READY, 1);

    // Streaming with OUT_READY held high
    cyc(1'b1, 8'h01, 1'b1);
    check("str_count1", COUNT, 1);
    check("str_ovalid1", OUT_VALID, 0);
    cyc(1'b1, 8'h02, 1'b1);
    check("str_ovalid2", OUT_VALID, 0);
    cyc(1'b1, 8'h03, 1'b1);
    check("str_ovalid3", OUT_VALID, 1);
    check("str_q3", Q, 8'h01);
    check("str_count3", COUNT, 3);
    cyc(1'b1, 8'h04, 1'b1);
    check("str_count4", COUNT, 3);
    check("str_q4", Q, 8'h02);
    drain(10);
    check("empty_ovalid", OUT_VALID, 0);
    check("empty_count", COUNT, 0);
    check("empty_qhold", Q, 8'h04);

    // Backpressure until full
    cyc(1'b1, 8'h11, 1'b0);
    cyc(1'b1, 8'h22, 1'b0);
    cyc(1'b1, 8'h33, 1'b0);
    cyc(1'b1, 8'h44, 1'b0);
    check("full_count", COUNT, 3);
    check("full_iready", IN_READY, 0);
    check("full_q", Q, 8'h11);
    OUT_READY = 1'b1;
    #1;
    check("full_pop_iready", IN_READY, 1);
    cyc(1'b1, 8'h44, 1'b1);
    check("pushpop_count", COUNT, 3);
    check("pushpop_q", Q, 8'h22);
    drain(10);

    // Bubble collapse
    cyc(1'b1, 8'h11, 1'b0);
    cyc(1'b0, 8'h00, 1'b0);
    cyc(1'b0, 8'h00, 1'b0);
    check("bub_ovalid", OUT_VALID, 1);
    check("bub_q", Q, 8'h11);
    check("bub_count1", COUNT, 1);
    repeat (3) cyc(1'b0, 8'h00, 1'b0);
    check("bub_iready", IN_READY, 1);
    cyc(1'b1, 8'h22, 1'b0);
    check("bub_count2", COUNT, 2);
    drain(10);

    // Scan shift from a freshly reset chain
    do_reset();
    RSTB = 1'b1;
    prior = '0;
    for (int s = 0; s < DEPTH; s++) prior[s*(WIDTH+1)+1 +: WIDTH] = RV;
    pat = '0;
    pat[0]       = 1'b1;
    pat[8:1]     = 8'hC3;
    pat[9]       = 1'b0;
    pat[17:10]   = 8'h00;
    pat[18]      = 1'b1;
    pat[26:19]   = 8'h7E;
    SE = 1'b1; IN_VALID = 1'b1; OUT_READY = 1'b1; D = 8'hFF;
    for (int n = 0; n < CL; n++) begin
      SI = pat[CL-1-n];
      #1;
      check("so_shift", SO, prior[CL-1-n]);
      @(posedge CLK);
      #1;
    end
    check("scan_ovalid", OUT_VALID, 0);
    check("scan_iready", IN_READY, 0);
    check("scan_count", COUNT, 2);
    check("scan_q", Q, 8'h7E);
    check("scan_so", SO, 0);
    SE = 1'b0; IN_VALID = 1'b0; OUT_READY = 1'b0;
    #1;
    check("post_ovalid", OUT_VALID, 1);
    check("post_q", Q, 8'h7E);
    check("post_count", COUNT, 2);
    check("post_iready", IN_READY, 1);
    sb.push_back(8'h7E);
    sb.push_back(8'hC3);
    drain(10);

    // Reset while full and draining
    cyc(1'b1, 8'hA1, 1'b0);
    cyc(1'b1, 8'hB2, 1'b0);
    cyc(1'b1, 8'hC3, 1'b0);
    check("mid_full", COUNT, 3);
    RSTB = 1'b0;
    cyc(1'b1, 8'hD4, 1'b1);
    RSTB = 1'b1;
    sb.delete();
    check("mid_count", COUNT, 0);
    check("mid_ovalid", OUT_VALID, 0);
    check("mid_q", Q, RV);
    check("mid_qn", QN, 8'h5A);
    check("mid_iready", IN_READY, 1);
    cyc(1'b0, 8'h00, 1'b1);
    check("mid_after_ovalid", OUT_VALID, 0);
    check("mid_after_count", COUNT, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
